bdd_node_sequencer: RTL and testbench
=====================================

Name: bdd_node_sequencer

Overview:
- Initiator side of the linear-threshold node evaluator interface; drives the evaluator rather than responding to it.
- Holds a configurable decision-tree node table and accepts one sample of four 8-bit attributes at a time.
- For each internal node, presents the sample plus that node's coefficients/threshold to an external evaluator over a req/ack handshake.
- Uses the returned decision bit to pick the child; walks from root (node 0) to a leaf and returns the leaf's class label.

Parameters:
- NODE_AW, 4, node-table address width (2**NODE_AW nodes)
- LABEL_W, 4, class label width
- MAX_DEPTH, 15, evaluations allowed per sample before abort

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset: synchronous, active-high
- cfg_we  in  1  node-table write strobe
- cfg_addr  in  NODE_AW  node index
- cfg_data  in  NODE_W  node word, NODE_W = 2*NODE_AW+LABEL_W+49; fields msb->lsb: leaf(1), label(LABEL_W), left(NODE_AW), right(NODE_AW), thr(16), c4, c3, c2, c1 (8 each)
- cfg_ready  out  1  high only in IDLE; writes with cfg_ready low are dropped
- s_valid  in  1  sample valid
- s_ready  out  1  sample accept (high in IDLE)
- s_a1..s_a4  in  8 each  unsigned attributes
- eval_req  out  1  evaluation request
- eval_a1..eval_a4  out  8 each  latched attributes
- eval_c1..eval_c4  out  8 each  current node coefficients
- eval_thr  out  16  current node threshold
- eval_ack  in  1  evaluator result valid
- eval_out  in  1  1 = weighted sum < thr
- r_valid  out  1  result valid
- r_ready  in  1  result accept
- r_label  out  LABEL_W  leaf label
- r_err  out  1  depth abort flag (label forced 0)

Behaviour:
- Reset: state IDLE, s_ready=1, cfg_ready=1, eval_req=0, r_valid=0, r_label=0, r_err=0, all eval_* data outputs 0, node pointer 0, hop count 0. Node table is not cleared. Reset mid-traversal aborts the sample with no result produced.
- Node table: synchronous write in IDLE; synchronous read with 1-cycle latency.
- FSM: IDLE -> FETCH -> CHECK -> (EVAL -> FETCH)* -> DONE -> IDLE.
- IDLE: on s_valid&s_ready, latch s_a1..s_a4 into eval_a*, set ptr=0, hops=0, go FETCH. cfg_we and s_valid both high in the same cycle: the write is performed and the sample is accepted; the sample sees the new node data.
- FETCH: read address = ptr; go CHECK.
- CHECK: register node word. If leaf=1: r_label=label, r_err=0, go DONE. Else if hops==MAX_DEPTH: r_label=0, r_err=1, go DONE. Else drive eval_c*/eval_thr from node, go EVAL.
- EVAL: eval_req=1 with all eval_* data stable until eval_ack. On eval_ack: ptr = eval_out ? left : right; hops++; eval_req=0 next cycle; go FETCH. eval_ack while eval_req=0 is ignored. No timeout on ack.
- DONE: r_valid=1, label/err held stable until r_ready; r_valid&r_ready -> IDLE, r_valid=0. s_ready=0 in every non-IDLE state.
- Latency: root leaf gives r_valid 3 cycles after the accept edge. Each internal node adds 2 cycles plus evaluator ack latency (ack in the first EVAL cycle = +3).
- Child index pointing to itself or forming a loop is terminated by the MAX_DEPTH abort.

Optional Feature:
- Macro: BDD_SEQ_STATS_EN.
- Defined: adds outputs stat_samples (16) and stat_evals (16).
  - stat_samples increments on each r_valid&r_ready.
  - stat_evals increments on each eval_req&eval_ack.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: no such ports and no counter logic; all other behaviour is identical.

Test Plan:
- Root leaf: node0 = leaf, label 5; send sample -> r_valid in 3 cycles, r_label=5, r_err=0, eval_req never asserted.
- Two-level tree: node0 = internal (left=1, right=2, c=1,1,1,1, thr=100); node1 = leaf label 3; node2 = leaf label 9; A=10,10,10,10; evaluator acks eval_out=1 -> label 3. Rerun with eval_out=0 -> label 9. Eval outputs equal A and the node coefficients while eval_req is high.
- Ack delay: evaluator holds ack off 5 cycles -> eval_req and eval_* stay stable throughout; one hop counted; result is correct.
- Loop abort: node0 internal with left=right=0, evaluator always acks -> exactly 15 evals, then r_valid, r_err=1, r_label=0.
- Backpressure/config: hold r_ready=0 for 4 cycles -> r_valid and r_label stable, s_ready=0, cfg_we dropped (table unchanged). Assert rst during EVAL -> next cycle eval_req=0 and state IDLE; a new sample then completes normally.
- With BDD_SEQ_STATS_EN: run the 2-level test 3 times -> stat_samples=3, stat_evals=3.

Source files
------------

// File: rtl/bdd_node_sequencer.sv
// Decision-tree walker: steps through the node table from the root, asks an external
// evaluator for each internal-node decision, and returns the leaf label. Optional counters: BDD_SEQ_STATS_EN.
module bdd_node_sequencer #(
  parameter  int NODE_AW   = 4,
  parameter  int LABEL_W   = 4,
  parameter  int MAX_DEPTH = 15,
  localparam int NODE_W    = 2*NODE_AW+LABEL_W+49
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [NODE_AW-1:0] cfg_addr,
  input  logic [NODE_W-1:0]  cfg_data,
  output logic               cfg_ready,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [7:0]         s_a1,
  input  logic [7:0]         s_a2,
  input  logic [7:0]         s_a3,
  input  logic [7:0]         s_a4,
  output logic               eval_req,
  output logic [7:0]         eval_a1,
  output logic [7:0]         eval_a2,
  output logic [7:0]         eval_a3,
  output logic [7:0]         eval_a4,
  output logic [7:0]         eval_c1,
  output logic [7:0]         eval_c2,
  output logic [7:0]         eval_c3,
  output logic [7:0]         eval_c4,
  output logic [15:0]        eval_thr,
  input  logic               eval_ack,
  input  logic               eval_out,
  output logic               r_valid,
  input  logic               r_ready,
  output logic [LABEL_W-1:0] r_label,
  output logic               r_err
`ifdef BDD_SEQ_STATS_EN
  ,
  output logic [15:0]        stat_samples,
  output logic [15:0]        stat_evals
`endif
);

  localparam int HW = $clog2(MAX_DEPTH+1);

  typedef struct packed {
    logic               leaf;
    logic [LABEL_W-1:0] label;
    logic [NODE_AW-1:0] left;
    logic [NODE_AW-1:0] right;
    logic [15:0]        thr;
    logic [3:0][7:0]    c;
  } node_t;

  typedef enum logic [2:0] {IDLE, FETCH, CHECK, EVAL, DONE} state_t;

  state_t             state, nstate;
  node_t              mem [2**NODE_AW];
  node_t              rdata;
  logic [3:0][7:0]    attr_q, coef_q;
  logic [15:0]        thr_q;
  logic [NODE_AW-1:0] ptr;
  logic [HW-1:0]      hops;
  logic [LABEL_W-1:0] label_q;
  logic               err_q;

  // Writes are only taken in IDLE, so the read port never races a write mid-walk.
  always_ff @(posedge clk) begin
    if (cfg_we && state == IDLE) mem[cfg_addr] <= node_t'(cfg_data);
    rdata <= mem[ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (s_valid) nstate = FETCH;
      FETCH:   nstate = CHECK;
      CHECK:   nstate = (rdata.leaf || hops == HW'(MAX_DEPTH)) ? DONE : EVAL;
      EVAL:    if (eval_ack) nstate = FETCH;
      DONE:    if (r_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      attr_q  <= '0;
      coef_q  <= '0;
      thr_q   <= '0;
      ptr     <= '0;
      hops    <= '0;
      label_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (s_valid) begin
          attr_q <= {s_a4, s_a3, s_a2, s_a1};
          ptr    <= '0;
          hops   <= '0;
        end
        CHECK: begin
          if (rdata.leaf) begin
            label_q <= rdata.label;
            err_q   <= 1'b0;
          end else if (hops == HW'(MAX_DEPTH)) begin
            label_q <= '0;
            err_q   <= 1'b1;
          end else begin
            coef_q <= rdata.c;
            thr_q  <= rdata.thr;
          end
        end
        // rdata still holds the current node: ptr is frozen until the ack.
        EVAL: if (eval_ack) begin
          ptr  <= eval_out ? rdata.left : rdata.right;
          hops <= hops + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign s_ready   = (state == IDLE);
  assign cfg_ready = (state == IDLE);
  assign eval_req  = (state == EVAL);
  assign r_valid   = (state == DONE);
  assign r_label   = label_q;
  assign r_err     = err_q;
  assign eval_a1   = attr_q[0];
  assign eval_a2   = attr_q[1];
  assign eval_a3   = attr_q[2];
  assign eval_a4   = attr_q[3];
  assign eval_c1   = coef_q[0];
  assign eval_c2   = coef_q[1];
  assign eval_c3   = coef_q[2];
  assign eval_c4   = coef_q[3];
  assign eval_thr  = thr_q;

`ifdef BDD_SEQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_samples <= '0;
      stat_evals   <= '0;
    end else begin
      if (r_valid && r_ready && stat_samples != 16'hFFFF) stat_samples <= stat_samples + 1'b1;
      if (eval_req && eval_ack && stat_evals != 16'hFFFF) stat_evals <= stat_evals + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bdd_node_sequencer.sv
// Bench for bdd_node_sequencer: vector table plus hand sequences for backpressure and reset.
module tb_bdd_node_sequencer;
  localparam int NAW = 4, LW = 4, NW = 2*NAW+LW+49;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, cfg_we, cfg_ready, s_valid, s_ready, eval_req, eval_ack, eval_out;
  logic           r_valid, r_ready, r_err;
  logic [NAW-1:0] cfg_addr;
  logic [NW-1:0]  cfg_data;
  logic [7:0]     s_a1, s_a2, s_a3, s_a4, eval_a1, eval_a2, eval_a3, eval_a4;
  logic [7:0]     eval_c1, eval_c2, eval_c3, eval_c4;
  logic [15:0]    eval_thr;
  logic [LW-1:0]  r_label;
`ifdef BDD_SEQ_STATS_EN
  logic [15:0]    stat_samples, stat_evals;
`endif

  bdd_node_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .s_valid(s_valid), .s_ready(s_ready),
    .s_a1(s_a1), .s_a2(s_a2), .s_a3(s_a3), .s_a4(s_a4), .eval_req(eval_req),
    .eval_a1(eval_a1), .eval_a2(eval_a2), .eval_a3(eval_a3), .eval_a4(eval_a4),
    .eval_c1(eval_c1), .eval_c2(eval_c2), .eval_c3(eval_c3), .eval_c4(eval_c4),
    .eval_thr(eval_thr), .eval_ack(eval_ack), .eval_out(eval_out),
    .r_valid(r_valid), .r_ready(r_ready), .r_label(r_label), .r_err(r_err)
`ifdef BDD_SEQ_STATS_EN
    , .stat_samples(stat_samples), .stat_evals(stat_evals)
`endif
  );

  int n_chk = 0, n_fail = 0;
  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Evaluator model: acks after ack_delay idle cycles and checks presented data every request cycle.
  logic        ack_out;
  int          ack_delay, wait_cnt, evals;
  logic [31:0] exp_a, exp_c;
  logic [15:0] exp_thr;
  always @(negedge clk) begin
    if (eval_req) begin
      check("eval_attrs", {eval_a4, eval_a3, eval_a2, eval_a1}, exp_a);
      check("eval_coef", {eval_thr, eval_c4, eval_c3, eval_c2, eval_c1}, {exp_thr, exp_c});
      if (wait_cnt == ack_delay) begin
        eval_ack = 1'b1;
        eval_out = ack_out;
        evals++;
      end else eval_ack = 1'b0;
      wait_cnt++;
    end else begin
      eval_ack = 1'b0;
      wait_cnt = 0;
    end
  end

  typedef struct packed {logic [LW-1:0] label; logic err;} res_t;
  res_t sbq[$];
  always @(negedge clk) begin
    res_t e;
    if (!rst && r_valid && r_ready) begin
      check("sb_nonempty", sbq.size() > 0, 1);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("r_label", r_label, e.label);
        check("r_err", r_err, e.err);
      end
    end
  end

  function automatic logic [NW-1:0] mk(input logic leaf, input logic [LW-1:0] lab,
      input logic [NAW-1:0] l, input logic [NAW-1:0] r, input logic [15:0] thr, input logic [31:0] c);
    return {leaf, lab, l, r, thr, c};
  endfunction

  task automatic wr(input logic [NAW-1:0] ad, input logic [NW-1:0] d);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = ad; cfg_data = d;
    @(posedge clk); #1 cfg_we = 1'b0;
  endtask

  task automatic load_tree(input int id);
    case (id)
      0: wr(0, mk(1'b1, 4'd5, 0, 0, 16'd0, 32'h0));
      1: begin
        exp_c = 32'h01010101; exp_thr = 16'd100;
        wr(0, mk(1'b0, 4'd0, 1, 2, exp_thr, exp_c));
        wr(1, mk(1'b1, 4'd3, 0, 0, 16'd0, 32'h0));
        wr(2, mk(1'b1, 4'd9, 0, 0, 16'd0, 32'h0));
      end
      default: begin
        exp_c = 32'h02030405; exp_thr = 16'h1234;
        wr(0, mk(1'b0, 4'd7, 0, 0, exp_thr, exp_c));
      end
    endcase
  endtask

  task automatic run_sample(input logic [31:0] a, input logic aout, input int dly,
      input logic [LW-1:0] elab, input logic eerr, input int eevals, input int elat,
      input logic wr_en, input logic [NW-1:0] wr_d);
    int cyc, ev0;
    @(negedge clk);
    {s_a4, s_a3, s_a2, s_a1} = a; s_valid = 1'b1; exp_a = a;
    ack_out = aout; ack_delay = dly; ev0 = evals;
    cfg_we = wr_en; cfg_addr = '0; cfg_data = wr_d;
    check("s_ready_idle", s_ready, 1);
    @(posedge clk);
    sbq.push_back('{label: elab, err: eerr});
    #1 s_valid = 1'b0; cfg_we = 1'b0;
    cyc = 1;
    while (!r_valid && cyc < 400) begin @(posedge clk); #1; cyc++; end
    check("latency", cyc, elat);
    @(posedge clk); #1;
    check("back_to_idle", {s_ready, r_valid}, 2'b10);
    check("eval_count", evals - ev0, eevals);
  endtask

  typedef struct {
    int tree; logic [31:0] a; logic aout; int dly;
    logic [LW-1:0] lab; logic err; int nev; int lat;
  } vec_t;
  vec_t vt[7];

  initial begin
    int cyc;
    vt[0] = '{0, 32'h04030201, 1'b0, 0, 4'd5, 1'b0, 0, 3};
    vt[1] = '{1, 32'h0A0A0A0A, 1'b1, 0, 4'd3, 1'b0, 1, 6};
    vt[2] = '{1, 32'h0A0A0A0A, 1'b0, 0, 4'd9, 1'b0, 1, 6};
    vt[3] = '{1, 32'h0A0A0A0A, 1'b1, 5, 4'd3, 1'b0, 1, 11};
    vt[4] = '{2, 32'hFF0007C8, 1'b1, 0, 4'd0, 1'b1, 15, 48};
    vt[5] = '{2, 32'h11223344, 1'b0, 1, 4'd0, 1'b1, 15, 63};
    vt[6] = '{1, 32'h018000FF, 1'b0, 2, 4'd9, 1'b0, 1, 8};

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; s_valid = 1'b0;
    {s_a4, s_a3, s_a2, s_a1} = '0; r_ready = 1'b1; eval_ack = 1'b0; eval_out = 1'b0;
    ack_out = 1'b0; ack_delay = 0; wait_cnt = 0; evals = 0;
    exp_a = '0; exp_c = '0; exp_thr = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", {s_ready, cfg_ready, eval_req, r_valid, r_err}, 5'b11000);
    check("rst_label", r_label, 0);
    check("rst_eval_a", {eval_a4, eval_a3, eval_a2, eval_a1}, 0);
    check("rst_eval_c", {eval_thr, eval_c4, eval_c3, eval_c2, eval_c1}, 0);
`ifdef BDD_SEQ_STATS_EN
    check("rst_stats", {stat_samples, stat_evals}, 0);
`endif
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      load_tree(vt[i].tree);
      run_sample(vt[i].a, vt[i].aout, vt[i].dly, vt[i].lab, vt[i].err, vt[i].nev, vt[i].lat, 1'b0, '0);
    end

    // Config write in the accept cycle: the sample must see the new root.
    load_tree(0);
    run_sample(32'h0, 1'b0, 0, 4'd12, 1'b0, 0, 3, 1'b1, mk(1'b1, 4'd12, 0, 0, 16'd0, 32'h0));

    // Backpressure: result held, config write refused while busy.
    load_tree(0);
    r_ready = 1'b0;
    @(negedge clk); s_valid = 1'b1; {s_a4, s_a3, s_a2, s_a1} = 32'h55AA55AA;
    @(posedge clk); sbq.push_back('{label: 4'd5, err: 1'b0}); #1 s_valid = 1'b0;
    cyc = 0;
    while (!r_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("bp_rvalid_seen", r_valid, 1);
    @(negedge clk); cfg_we = 1'b1; cfg_addr = '0; cfg_data = mk(1'b1, 4'd7, 0, 0, 16'd0, 32'h0);
    repeat (4) begin
      @(posedge clk); #1;
      check("bp_hold", {r_valid, r_label, r_err, s_ready, cfg_ready}, {1'b1, 4'd5, 1'b0, 1'b0, 1'b0});
    end
    @(negedge clk); cfg_we = 1'b0; r_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {s_ready, r_valid}, 2'b10);
    run_sample(32'h0, 1'b0, 0, 4'd5, 1'b0, 0, 3, 1'b0, '0);

    // Reset while waiting on the evaluator: walk aborted, no result.
    load_tree(1);
    ack_delay = 20;
    @(negedge clk); s_valid = 1'b1; {s_a4, s_a3, s_a2, s_a1} = 32'h0A0A0A0A; exp_a = 32'h0A0A0A0A;
    @(posedge clk); #1 s_valid = 1'b0;
    cyc = 0;
    while (!eval_req && cyc < 20) begin @(posedge clk); #1; cyc++; end
    check("rst_eval_req_seen", eval_req, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_eval", {eval_req, s_ready, r_valid}, 3'b010);
    @(negedge clk); rst = 1'b0;
    run_sample(32'h0A0A0A0A, 1'b1, 0, 4'd3, 1'b0, 1, 6, 1'b0, '0);

`ifdef BDD_SEQ_STATS_EN
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("stats_clear", {stat_samples, stat_evals}, 0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) run_sample(32'h0A0A0A0A, i[0], 0, i[0] ? 4'd3 : 4'd9, 1'b0, 1, 6, 1'b0, '0);
    check("stat_samples", stat_samples, 3);
    check("stat_evals", stat_evals, 3);
`endif

    check("sb_drained", sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
